// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU-control decoder: ALUControl words, ALUOp codes, FSM states.
// Build option ALU_CTRL_MEXT_EN enables the RV32M decode and multi-cycle latency path.
package alu_ctrl_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLL  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01001;
    localparam logic [4:0] ALU_MUL  = 5'b10000;
    localparam logic [4:0] ALU_REMU = 5'b10111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decode into a control word plus illegal/multi-cycle/divide flags.
// With ALU_CTRL_MEXT_EN undefined, any M-extension encoding is reported as illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    output logic [4:0] ctrl,
    output logic       illegal,
    output logic       multi,
    output logic       is_div
);

    always_comb begin
        ctrl    = ALU_ADD;
        illegal = 1'b0;
        multi   = 1'b0;
        is_div  = 1'b0;
        if (alu_op == ALUOP_ADD) begin
            ctrl = ALU_ADD;
        end else if (alu_op == ALUOP_SUB) begin
            ctrl = ALU_SUB;
        end else if (opb5 && funct7b0) begin
`ifdef ALU_CTRL_MEXT_EN
            ctrl   = {2'b10, funct3};
            multi  = 1'b1;
            is_div = funct3[2];
`else
            ctrl    = ALU_ADD;
            illegal = 1'b1;
`endif
        end else begin
            // Shift-right arithmetic is selected by funct7[5] in both R and I forms.
            unique case (funct3)
                3'b000:  ctrl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  ctrl = ALU_SLL;
                3'b010:  ctrl = ALU_SLT;
                3'b011:  ctrl = ALU_SLTU;
                3'b100:  ctrl = ALU_XOR;
                3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  ctrl = ALU_OR;
                default: ctrl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// Registered, handshaked ALU-control decoder: IDLE -> (WAIT) -> HOLD with backpressure and flush.
// ALU_CTRL_MEXT_EN enables mul/div ops that hold WAIT for MUL_LAT/DIV_LAT cycles.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic              opb5,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              illegal,
    output logic              multi,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;
    logic              multi_q, multi_d;

    logic [4:0] dec_ctrl;
    logic       dec_illegal, dec_multi, dec_is_div;
    logic       accept;

    alu_ctrl_decode u_decode (
        .alu_op   (ALUOp),
        .opb5     (opb5),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .multi    (dec_multi),
        .is_div   (dec_is_div)
    );

    assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == ST_HOLD);
    assign ALUControl = ctrl_q;
    assign illegal    = illegal_q;
    assign multi      = multi_q;
`ifdef ALU_CTRL_MEXT_EN
    assign busy       = (state_q == ST_WAIT);
`else
    assign busy       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        multi_d   = multi_q;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: ;
        endcase
        // A new accept in HOLD overrides the return to IDLE (back-to-back transfer).
        if (accept) begin
            ctrl_d    = CTRL_W'(dec_ctrl);
            illegal_d = dec_illegal;
            multi_d   = dec_multi;
            if (dec_multi && dec_is_div && (DIV_LAT > 1)) begin
                state_d = ST_WAIT;
                cnt_d   = DIV_CNT;
            end else if (dec_multi && !dec_is_div && (MUL_LAT > 1)) begin
                state_d = ST_WAIT;
                cnt_d   = MUL_CNT;
            end else begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        end
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            multi_q   <= multi_d;
        end
    end

endmodule
